// File: rtl/ps2_keycode_decoder.sv
// rtl/ps2_keycode_decoder.sv - PS/2 keyboard frame receiver and HID-style keycode decoder
module ps2_keycode_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] keycode,
  output logic       key_press,
  output logic       key_release,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;

  logic          rx_busy;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          byte_valid;
  logic [7:0]    byte_data;

  state_t        state, state_nx;
  logic [7:0]    keycode_nx;
  logic          press_nx, release_nx;
  logic          is_make, is_break, is_ext;
  logic [7:0]    mapped;

  // Translate a scan code to its HID usage; unmapped codes yield 0x00
  function automatic logic [7:0] map_code(input logic ext, input logic [7:0] code);
    logic [7:0] r;
    r = 8'h00;
    if (!ext) begin
      case (code)
        8'h1D:   r = 8'h1A;
        8'h1B:   r = 8'h16;
        8'h1C:   r = 8'h04;
        8'h23:   r = 8'h07;
        8'h5A:   r = 8'h28;
        default: r = 8'h00;
      endcase
    end else begin
      case (code)
        8'h75:   r = 8'h52;
        8'h72:   r = 8'h51;
        8'h6B:   r = 8'h50;
        8'h74:   r = 8'h4F;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // Two-stage synchronisers plus a delayed copy of the clock for edge detection
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= PS2_Clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= PS2_Data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame receiver: start bit, 8 data bits LSB first, odd parity, stop; abandons stalled frames
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_busy    <= 1'b0;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (!rx_busy) begin
          // A high start bit is noise; stay idle
          if (!data_s2) begin
            rx_busy <= 1'b1;
            bit_cnt <= 4'd0;
          end
        end else if (bit_cnt < 4'd8) begin
          shift   <= {data_s2, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd8) begin
          par_bit <= data_s2;
          bit_cnt <= 4'd9;
        end else begin
          rx_busy <= 1'b0;
          bit_cnt <= 4'd0;
          if (data_s2 && (^{shift, par_bit})) begin
            byte_valid <= 1'b1;
            byte_data  <= shift;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (rx_busy) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_busy <= 1'b0;
          bit_cnt <= 4'd0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  // Decode state and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      keycode     <= 8'h00;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nx;
      keycode     <= keycode_nx;
      key_press   <= press_nx;
      key_release <= release_nx;
    end
  end

  // Prefix tracking and make/break resolution against the held key
  always_comb begin
    state_nx   = state;
    keycode_nx = keycode;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    is_make    = 1'b0;
    is_break   = 1'b0;
    is_ext     = 1'b0;
    mapped     = 8'h00;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == 8'hE0)      state_nx = EXT;
          else if (byte_data == 8'hF0) state_nx = BRK;
          else                         is_make  = 1'b1;
        end
        EXT: begin
          if (byte_data == 8'hE0)      state_nx = EXT;
          else if (byte_data == 8'hF0) state_nx = EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
          end
        end
        BRK: begin
          if (byte_data == 8'hF0) state_nx = BRK;
          else                    is_break = 1'b1;
        end
        EXT_BRK: begin
          if (byte_data == 8'hE0)      state_nx = EXT;
          else if (byte_data == 8'hF0) state_nx = EXT_BRK;
          else begin
            is_break = 1'b1;
            is_ext   = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
      mapped = map_code(is_ext, byte_data);
      if (is_make || is_break) begin
        state_nx = IDLE;
      end
      if (is_make && (mapped != 8'h00) && (mapped != keycode)) begin
        keycode_nx = mapped;
        press_nx   = 1'b1;
      end
      if (is_break && (mapped != 8'h00) && (mapped == keycode)) begin
        keycode_nx = 8'h00;
        release_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb/tb_ps2_keycode_decoder.sv - directed self-checking bench for ps2_keycode_decoder
module tb_ps2_keycode_decoder;

  localparam int TMO = 200;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic [7:0] keycode;
  logic       key_press, key_release, frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int press_cnt, release_cnt, err_cnt, press_lat, release_lat;
  int both_cnt = 0;
  int since_stop = -1;

  ps2_keycode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PS2_Clk(PS2_Clk),
    .PS2_Data(PS2_Data),
    .keycode(keycode),
    .key_press(key_press),
    .key_release(key_release),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    press_cnt = 0;
    release_cnt = 0;
    err_cnt = 0;
    press_lat = -1;
    release_lat = -1;
  endtask

  task automatic tick();
    @(negedge Clk);
    if (since_stop >= 0) since_stop++;
    if (key_press) begin
      press_cnt++;
      press_lat = since_stop;
    end
    if (key_release) begin
      release_cnt++;
      release_lat = since_stop;
    end
    if (frame_err) err_cnt++;
    if (key_press && key_release) both_cnt++;
  endtask

  task automatic ps2_bit(input logic v, input bit stop);
    PS2_Data = v;
    repeat (8) tick();
    PS2_Clk = 1'b0;
    if (stop) since_stop = 0;
    repeat (8) tick();
    PS2_Clk = 1'b1;
    repeat (8) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == 10);
  endtask

  initial begin
    repeat (4) @(negedge Clk);
    chk("reset_keycode", 32'(keycode), 32'h00);
    chk("reset_press", 32'(key_press), 32'h0);
    chk("reset_release", 32'(key_release), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);

    clear_counts();
    send_frame(8'h5A, 0);
    chk("enter_keycode", 32'(keycode), 32'h28);
    chk("enter_press_cnt", press_cnt, 1);
    chk("enter_press_lat", press_lat, 4);
    chk("enter_release_cnt", release_cnt, 0);

    clear_counts();
    send_frame(8'hF0, 0);
    send_frame(8'h5A, 0);
    chk("enter_brk_keycode", 32'(keycode), 32'h00);
    chk("enter_brk_release_cnt", release_cnt, 1);
    chk("enter_brk_release_lat", release_lat, 4);
    chk("enter_brk_press_cnt", press_cnt, 0);

    clear_counts();
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    chk("up_keycode", 32'(keycode), 32'h52);
    chk("up_press_cnt", press_cnt, 1);
    clear_counts();
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    chk("up_brk_keycode", 32'(keycode), 32'h00);
    chk("up_brk_release_cnt", release_cnt, 1);

    clear_counts();
    send_frame(8'h1D, 0);
    chk("w_keycode", 32'(keycode), 32'h1A);
    clear_counts();
    send_frame(8'hE0, 0);
    send_frame(8'h72, 0);
    chk("down_keycode", 32'(keycode), 32'h51);
    chk("down_press_cnt", press_cnt, 1);
    clear_counts();
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    chk("w_brk_keycode", 32'(keycode), 32'h51);
    chk("w_brk_release_cnt", release_cnt, 0);
    chk("w_brk_press_cnt", press_cnt, 0);

    clear_counts();
    send_frame(8'h5A, 1);
    chk("parity_err_cnt", err_cnt, 1);
    chk("parity_keycode", 32'(keycode), 32'h51);
    chk("parity_press_cnt", press_cnt, 0);
    clear_counts();
    send_frame(8'h1B, 0);
    chk("s_keycode", 32'(keycode), 32'h16);
    chk("s_press_cnt", press_cnt, 1);
    clear_counts();
    send_frame(8'h1B, 0);
    chk("repeat_keycode", 32'(keycode), 32'h16);
    chk("repeat_press_cnt", press_cnt, 0);
    clear_counts();
    send_frame(8'h12, 0);
    chk("unmapped_keycode", 32'(keycode), 32'h16);
    chk("unmapped_press_cnt", press_cnt, 0);

    clear_counts();
    ps2_bit(1'b1, 0);
    send_frame(8'h23, 0);
    chk("hi_start_err_cnt", err_cnt, 0);
    chk("d_keycode", 32'(keycode), 32'h07);

    clear_counts();
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    repeat (TMO + 10) tick();
    chk("timeout_keycode", 32'(keycode), 32'h07);
    chk("timeout_press_cnt", press_cnt, 0);
    chk("timeout_err_cnt", err_cnt, 0);
    clear_counts();
    send_frame(8'h1C, 0);
    chk("a_keycode", 32'(keycode), 32'h04);
    chk("a_press_cnt", press_cnt, 1);
    chk("a_err_cnt", err_cnt, 0);

    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b1, 0);
    Reset = 1'b0;
    #2;
    chk("midrst_keycode", 32'(keycode), 32'h00);
    chk("midrst_press", 32'(key_press), 32'h0);
    chk("midrst_release", 32'(key_release), 32'h0);
    chk("midrst_err", 32'(frame_err), 32'h0);
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    clear_counts();
    send_frame(8'h5A, 0);
    chk("post_rst_keycode", 32'(keycode), 32'h28);
    chk("post_rst_press_cnt", press_cnt, 1);
    chk("post_rst_err_cnt", err_cnt, 0);

    chk("press_release_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
